operand_fetch_stage: RTL and testbench

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/of_pkg.sv | 39 +++
 rtl/of_imm_gen.sv | 38 +++
 rtl/operand_fetch_stage.sv | 146 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// rtl/of_pkg.sv - opcode, immediate-modifier and field-position definitions for the operand fetch stage
package of_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_NOP  = 5'b01101,
        OP_LD   = 5'b01110,
        OP_ST   = 5'b01111,
        OP_BEQ  = 5'b10000,
        OP_BGT  = 5'b10001,
        OP_B    = 5'b10010,
        OP_CALL = 5'b10011,
        OP_RET  = 5'b10100
    } opcode_e;

    typedef enum logic [1:0] {
        MOD_ZEXT = 2'b00,
        MOD_SEXT = 2'b01,
        MOD_HIGH = 2'b10,
        MOD_ZERO = 2'b11
    } imm_mod_e;

    localparam int F_OPC_HI = 31;
    localparam int F_OPC_LO = 27;
    localparam int F_IBIT   = 26;
    localparam int F_RD_HI  = 25;
    localparam int F_RD_LO  = 22;
    localparam int F_RS1_HI = 21;
    localparam int F_RS1_LO = 18;
    localparam int F_RS2_HI = 17;
    localparam int F_RS2_LO = 14;
    localparam int F_MOD_HI = 17;
    localparam int F_MOD_LO = 16;
    localparam int F_IMM_HI = 15;
    localparam int F_IMM_LO = 0;
    localparam int F_OFF_HI = 26;
    localparam int F_OFF_LO = 0;

endpackage

// File: rtl/of_imm_gen.sv
// rtl/of_imm_gen.sv - combinational immediate expansion and branch target generation
module of_imm_gen
    import of_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_immx,
    output logic [XLEN-1:0] o_btarget
);

    logic [15:0]     w_imm16;
    logic [1:0]      w_mod;
    logic [26:0]     w_off;
    logic [XLEN-1:0] w_imm_sext;
    logic [XLEN-1:0] w_off_sext;

    assign w_imm16    = i_instr[F_IMM_HI:F_IMM_LO];
    assign w_mod      = i_instr[F_MOD_HI:F_MOD_LO];
    assign w_off      = i_instr[F_OFF_HI:F_OFF_LO];
    assign w_imm_sext = {{(XLEN-16){w_imm16[15]}}, w_imm16};
    assign w_off_sext = {{(XLEN-27){w_off[26]}}, w_off};

    // Shifting the sign-extended imm16 left by 16 yields bit 31 replicated above it for any XLEN.
    always_comb begin
        o_immx = '0;
        case (w_mod)
            MOD_ZEXT: o_immx = {{(XLEN-16){1'b0}}, w_imm16};
            MOD_SEXT: o_immx = w_imm_sext;
            MOD_HIGH: o_immx = w_imm_sext << 16;
            default:  o_immx = '0;
        endcase
    end

    assign o_btarget = i_pc + (w_off_sext << 2);

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - decode/operand fetch with load-use bubble insertion; OF_FWD_EN enables writeback forwarding
module operand_fetch_stage
    import of_pkg::*;
#(
    parameter int         XLEN   = 32,
    parameter logic [3:0] RA_REG = 4'd15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [3:0]      rf_addr1,
    output logic [3:0]      rf_addr2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    input  logic            wb_en,
    input  logic [3:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_opcode,
    output logic            out_imm,
    output logic [3:0]      out_rd,
    output logic [XLEN-1:0] out_immx,
    output logic [XLEN-1:0] out_btarget,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_stval,
    output logic [15:0]     bubble_count
);

    logic [4:0]      w_opcode;
    logic            w_ibit;
    logic [3:0]      w_rd;
    logic [3:0]      w_rs1;
    logic [3:0]      w_rs2;
    logic [XLEN-1:0] w_immx;
    logic [XLEN-1:0] w_btarget;
    logic [XLEN-1:0] w_d1;
    logic [XLEN-1:0] w_d2;
    logic            w_uses2;
    logic            w_hazard;
    logic            w_accept;
    logic            w_fire;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_opcode;
    logic            r_imm;
    logic [3:0]      r_rd;
    logic [XLEN-1:0] r_immx;
    logic [XLEN-1:0] r_btarget;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_stval;
    logic [15:0]     r_bubbles;

    assign w_opcode = in_instr[F_OPC_HI:F_OPC_LO];
    assign w_ibit   = in_instr[F_IBIT];
    assign w_rd     = in_instr[F_RD_HI:F_RD_LO];
    assign w_rs1    = in_instr[F_RS1_HI:F_RS1_LO];
    assign w_rs2    = in_instr[F_RS2_HI:F_RS2_LO];

    assign rf_addr1 = (w_opcode == OP_RET) ? RA_REG : w_rs1;
    assign rf_addr2 = (w_opcode == OP_ST)  ? w_rd   : w_rs2;

`ifdef OF_FWD_EN
    assign w_d1 = (wb_en && (wb_addr == rf_addr1)) ? wb_data : rf_data1;
    assign w_d2 = (wb_en && (wb_addr == rf_addr2)) ? wb_data : rf_data2;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_en, wb_addr, wb_data};
    assign w_d1 = rf_data1;
    assign w_d2 = rf_data2;
`endif

    of_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr   (in_instr),
        .i_pc      (in_pc),
        .o_immx    (w_immx),
        .o_btarget (w_btarget)
    );

    // Port 2 only matters for register-register ops and for store data.
    assign w_uses2  = !w_ibit || (w_opcode == OP_ST);
    assign w_hazard = r_valid && (r_opcode == OP_LD) && in_valid &&
                      ((rf_addr1 == r_rd) || (w_uses2 && (rf_addr2 == r_rd)));

    assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_fire   = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_opcode  <= '0;
            r_imm     <= 1'b0;
            r_rd      <= '0;
            r_immx    <= '0;
            r_btarget <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_stval   <= '0;
            r_bubbles <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_pc      <= in_pc;
                r_opcode  <= w_opcode;
                r_imm     <= w_ibit;
                r_rd      <= w_rd;
                r_immx    <= w_immx;
                r_btarget <= w_btarget;
                r_op1     <= w_d1;
                r_op2     <= w_ibit ? w_immx : w_d2;
                r_stval   <= w_d2;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            // The LD leaving while its consumer waits is exactly what opens the bubble.
            if (w_fire && w_hazard && !flush && (r_bubbles != 16'hFFFF)) begin
                r_bubbles <= r_bubbles + 16'd1;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_opcode   = r_opcode;
    assign out_imm      = r_imm;
    assign out_rd       = r_rd;
    assign out_immx     = r_immx;
    assign out_btarget  = r_btarget;
    assign out_op1      = r_op1;
    assign out_op2      = r_op2;
    assign out_stval    = r_stval;
    assign bubble_count = r_bubbles;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [3:0]  rf_addr1;
    logic [3:0]  rf_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_opcode;
    logic        out_imm;
    logic [3:0]  out_rd;
    logic [31:0] out_immx;
    logic [31:0] out_btarget;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_stval;
    logic [15:0] bubble_count;
    logic        rf_zero;

    logic        v64_valid;
    logic        r64_ready;
    logic [31:0] i64_instr;
    logic [63:0] i64_pc;
    logic [3:0]  a64_1;
    logic [3:0]  a64_2;
    logic        o64_valid;
    logic [63:0] o64_pc;
    logic [4:0]  o64_opcode;
    logic        o64_imm;
    logic [3:0]  o64_rd;
    logic [63:0] o64_immx;
    logic [63:0] o64_btarget;
    logic [63:0] o64_op1;
    logic [63:0] o64_op2;
    logic [63:0] o64_stval;
    logic [15:0] b64_count;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch_stage #(.XLEN(32), .RA_REG(4'd15)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_imm(out_imm), .out_rd(out_rd),
        .out_immx(out_immx), .out_btarget(out_btarget), .out_op1(out_op1),
        .out_op2(out_op2), .out_stval(out_stval), .bubble_count(bubble_count)
    );

    operand_fetch_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(v64_valid), .in_ready(),
        .in_instr(i64_instr), .in_pc(i64_pc), .rf_addr1(a64_1), .rf_addr2(a64_2),
        .rf_data1(64'h0), .rf_data2(64'h0), .wb_en(1'b0), .wb_addr(4'h0),
        .wb_data(64'h0), .flush(1'b0), .out_valid(o64_valid), .out_ready(r64_ready),
        .out_pc(o64_pc), .out_opcode(o64_opcode), .out_imm(o64_imm), .out_rd(o64_rd),
        .out_immx(o64_immx), .out_btarget(o64_btarget), .out_op1(o64_op1),
        .out_op2(o64_op2), .out_stval(o64_stval), .bubble_count(b64_count)
    );

    function automatic logic [31:0] p1v(input logic [3:0] a);
        return {16'hC0DE, 12'h000, a};
    endfunction

    function automatic logic [31:0] p2v(input logic [3:0] a);
        return {16'hBEEF, 12'h000, a};
    endfunction

    always_comb begin
        rf_data1 = rf_zero ? 32'h0 : p1v(rf_addr1);
        rf_data2 = rf_zero ? 32'h0 : p2v(rf_addr2);
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [31:0] immx;
        logic [31:0] bt;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] stv;
    } vec_t;

    vec_t vt[7];

    localparam logic [31:0] LD_R3   = 32'h74C0_0000;
    localparam logic [31:0] ADD_DEP = 32'h004C_8000;
    localparam logic [31:0] ADD_A   = 32'h0144_8000;
    localparam logic [31:0] ADD_B   = 32'h0190_0000;
    localparam logic [31:0] ADD_FWD = 32'h0014_0000;

    initial begin
        vt[0] = '{32'h0048_C000, 32'h0000_1000, 4'd2,  4'd3,  32'h0000_C000, 32'h0123_1000, p1v(4'd2),  p2v(4'd3),  p2v(4'd3)};
        vt[1] = '{32'h0515_8000, 32'h0000_2000, 4'd5,  4'd6,  32'hFFFF_8000, 32'hF456_2000, p1v(4'd5),  32'hFFFF_8000, p2v(4'd6)};
        vt[2] = '{32'h0C06_1234, 32'h0000_0000, 4'd1,  4'd8,  32'h1234_0000, 32'hF018_48D0, p1v(4'd1),  32'h1234_0000, p2v(4'd8)};
        vt[3] = '{32'h7DE7_FFFF, 32'h0000_0004, 4'd9,  4'd7,  32'h0000_0000, 32'hF7A0_0000, p1v(4'd9),  32'h0000_0000, p2v(4'd7)};
        vt[4] = '{32'hA00C_8000, 32'h0000_0010, 4'd15, 4'd2,  32'h0000_8000, 32'h0032_0010, p1v(4'd15), p2v(4'd2),  p2v(4'd2)};
        vt[5] = '{32'h97FF_FFFF, 32'h0000_0100, 4'd15, 4'd15, 32'h0000_0000, 32'h0000_00FC, p1v(4'd15), 32'h0000_0000, p2v(4'd15)};
        vt[6] = '{32'h7482_8000, 32'hFFFF_FFF0, 4'd0,  4'd10, 32'h8000_0000, 32'hF209_FFF0, p1v(4'd0),  32'h8000_0000, p2v(4'd10)};

        clk = 0; reset = 0; in_valid = 0; in_instr = 0; in_pc = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1; rf_zero = 0;
        v64_valid = 0; r64_ready = 1; i64_instr = 0; i64_pc = 0;

        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_immx", out_immx, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_bt", out_btarget, 0);
        chk("rst_bubbles", bubble_count, 0);
        reset = 1;
        #1 chk("rst_in_ready", in_ready, 1);

        v64_valid = 1; i64_instr = 32'h0402_8000; i64_pc = 64'h0;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] ins;
            ins = vt[i].instr;
            in_valid = 1; in_instr = ins; in_pc = vt[i].pc;
            #1;
            chk($sformatf("v%0d_addr1", i), rf_addr1, vt[i].a1);
            chk($sformatf("v%0d_addr2", i), rf_addr2, vt[i].a2);
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            if (i == 0) begin
                v64_valid = 0;
                chk("x64_immx", o64_immx, 64'hFFFF_FFFF_8000_0000);
                chk("x64_bt", o64_btarget, 64'hFFFF_FFFF_F00A_0000);
            end
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_pc", i), out_pc, vt[i].pc);
            chk($sformatf("v%0d_opcode", i), out_opcode, ins[31:27]);
            chk($sformatf("v%0d_imm", i), out_imm, ins[26]);
            chk($sformatf("v%0d_rd", i), out_rd, ins[25:22]);
            chk($sformatf("v%0d_immx", i), out_immx, vt[i].immx);
            chk($sformatf("v%0d_bt", i), out_btarget, vt[i].bt);
            chk($sformatf("v%0d_op1", i), out_op1, vt[i].op1);
            chk($sformatf("v%0d_op2", i), out_op2, vt[i].op2);
            chk($sformatf("v%0d_stval", i), out_stval, vt[i].stv);
        end
        in_valid = 0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_bubbles", bubble_count, 0);

        in_valid = 1; in_instr = LD_R3; in_pc = 32'h40;
        tick();
        in_instr = ADD_DEP; in_pc = 32'h44;
        #1 chk("haz_in_ready", in_ready, 0);
        tick();
        chk("haz_bubble_valid", out_valid, 0);
        chk("haz_bubble_cnt", bubble_count, 1);
        chk("haz_accept_ready", in_ready, 1);
        tick();
        chk("haz_dep_valid", out_valid, 1);
        chk("haz_dep_rd", out_rd, 1);
        chk("haz_dep_op1", out_op1, p1v(4'd3));
        in_valid = 0;
        tick();
        chk("haz_end_cnt", bubble_count, 1);

        out_ready = 0; in_valid = 1; in_instr = ADD_A; in_pc = 32'h80;
        tick();
        in_instr = ADD_B; in_pc = 32'h84;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_in_ready", k), in_ready, 0);
            chk($sformatf("stall%0d_valid", k), out_valid, 1);
            chk($sformatf("stall%0d_rd", k), out_rd, 5);
            chk($sformatf("stall%0d_op1", k), out_op1, p1v(4'd1));
            chk($sformatf("stall%0d_pc", k), out_pc, 32'h80);
            tick();
        end
        out_ready = 1;
        #1 chk("release_in_ready", in_ready, 1);
        tick();
        chk("release_valid", out_valid, 1);
        chk("release_rd", out_rd, 6);
        chk("release_pc", out_pc, 32'h84);
        chk("release_op2", out_op2, p2v(4'd0));

        out_ready = 0; in_instr = ADD_A; in_pc = 32'h90;
        tick();
        flush = 1; in_instr = ADD_B; in_pc = 32'h94;
        #1 chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("flush_valid", out_valid, 0);
        tick();
        chk("flush_not_accepted", out_valid, 0);

        in_valid = 1; in_instr = LD_R3; in_pc = 32'hA0;
        tick();
        in_instr = ADD_DEP; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("flush_haz_valid", out_valid, 0);
        chk("flush_haz_cnt", bubble_count, 1);

        in_valid = 1; in_instr = LD_R3;
        tick();
        in_instr = ADD_DEP;
        tick();
        chk("rb_bubble_valid", out_valid, 0);
        chk("rb_bubble_cnt", bubble_count, 2);
        reset = 0;
        tick();
        chk("rb_cnt", bubble_count, 0);
        chk("rb_valid", out_valid, 0);
        chk("rb_op1", out_op1, 0);
        reset = 1; in_valid = 0;
        #1 chk("rb_in_ready", in_ready, 1);
        tick();
        chk("rb_stay_idle", out_valid, 0);

        rf_zero = 1; wb_en = 1; wb_addr = 4'd5; wb_data = 32'h0000_DEAD;
        in_valid = 1; in_instr = ADD_FWD; in_pc = 32'hC0;
        tick();
        in_valid = 0;
`ifdef OF_FWD_EN
        chk("fwd_op1", out_op1, 32'h0000_DEAD);
`else
        chk("fwd_op1", out_op1, 32'h0000_0000);
`endif
        chk("fwd_op2", out_op2, 32'h0000_0000);
        wb_en = 0; rf_zero = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
